display_scanner: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds a double-buffered display word, steps a digit pointer at a programmable rate, and shares one `hexto7seg` decoder across all digits. It drives the active-low `digitselect` and `segments` pins directly. New values are accepted with a single-cycle load strobe and committed only at a frame boundary, so a displayed frame never mixes old and new data.

---
 rtl/display_pkg.sv | 12 +
 rtl/display_scanner_if.sv | 20 ++
 rtl/display_scanner_hexto7seg.sv | 30 +++
 rtl/display_scanner.sv | 92 +++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and display-word type for the seven-segment scanner
package display_pkg;
    localparam int MAX_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int DP_BIT = 0;

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] value;
        logic [MAX_DIGITS-1:0]   en_mask;
        logic [MAX_DIGITS-1:0]   dp_mask;
    } disp_word_t;
endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if: load bus and display pins of the scan controller
interface display_scanner_if #(parameter int NDIGITS = 8);
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     en_mask;
    logic [NDIGITS-1:0]     dp_mask;
    logic                   pending;
    logic                   frame_done;
    logic [NDIGITS-1:0]     digitselect;
    logic [7:0]             segments;

    modport master (
        output load, value, en_mask, dp_mask,
        input  pending, frame_done, digitselect, segments
    );
    modport slave (
        input  load, value, en_mask, dp_mask,
        output pending, frame_done, digitselect, segments
    );
endinterface

// File: rtl/display_scanner_hexto7seg.sv
// hexto7seg: hex nibble to active-low segments {a,b,c,d,e,f,g,dp}, dp left dark
module hexto7seg
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = 8'h03;
            4'h1: o_seg = 8'h9F;
            4'h2: o_seg = 8'h25;
            4'h3: o_seg = 8'h0D;
            4'h4: o_seg = 8'h99;
            4'h5: o_seg = 8'h49;
            4'h6: o_seg = 8'h41;
            4'h7: o_seg = 8'h1F;
            4'h8: o_seg = 8'h01;
            4'h9: o_seg = 8'h09;
            4'hA: o_seg = 8'h11;
            4'hB: o_seg = 8'hC1;
            4'hC: o_seg = 8'h63;
            4'hD: o_seg = 8'h85;
            4'hE: o_seg = 8'h61;
            4'hF: o_seg = 8'h71;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan of a double-buffered word onto a common-anode display
module display_scanner
    import display_pkg::*;
#(
    parameter int NDIGITS      = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input logic             clk,
    input logic             reset,
    display_scanner_if.slave bus
);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    disp_word_t         r_shadow, r_active, w_in;
    logic               r_pending, r_frame_done;
    logic [NDIGITS-1:0] r_digitselect, w_sel;
    logic [7:0]         r_segments, w_hex_seg, w_seg;
    logic               w_slot_end, w_wrap, w_en, w_dp, w_blank;
    logic [3:0]         w_nibble;

    always_comb begin
        w_in = '0;
        w_in.value[4*NDIGITS-1:0] = bus.value;
        w_in.en_mask[NDIGITS-1:0] = bus.en_mask;
        w_in.dp_mask[NDIGITS-1:0] = bus.dp_mask;
    end

    assign w_slot_end = r_cnt == CNT_LAST;
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
    assign w_nibble   = r_active.value[{r_idx, 2'b00} +: 4];
    assign w_en       = r_active.en_mask[r_idx];
    assign w_dp       = r_active.dp_mask[r_idx];
    assign w_blank    = r_cnt < CW'(BLANK_CYCLES);

    hexto7seg u_hex (.i_hex(w_nibble), .o_seg(w_hex_seg));

    // DP override and slot blanking sit after the single shared decoder
    always_comb begin
        w_seg = w_en ? w_hex_seg : SEG_BLANK;
        if (w_en && w_dp) w_seg[DP_BIT] = 1'b0;
        w_sel = (w_en && !w_blank) ? ~(NDIGITS'(1) << r_idx) : '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end
    end

    // a load landing on the wrap edge skips the shadow and shows next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_wrap) begin
            if (bus.load) r_active <= w_in;
            else if (r_pending) r_active <= r_shadow;
            r_pending <= 1'b0;
        end else if (bus.load) begin
            r_shadow  <= w_in;
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done  <= 1'b0;
            r_digitselect <= '1;
            r_segments    <= SEG_BLANK;
        end else begin
            r_frame_done  <= w_wrap;
            r_digitselect <= w_sel;
            r_segments    <= w_seg;
        end
    end

    assign bus.pending     = r_pending;
    assign bus.frame_done  = r_frame_done;
    assign bus.digitselect = r_digitselect;
    assign bus.segments    = r_segments;
endmodule
